// File: rtl/demux_1x16_seq.sv
// Sequential 1:N time-division demultiplexer: a serial bit stream, framed by sof,
// is collected slot by slot into a shadow register and published as a parallel word.

module demux_1x16_lane (
   input  logic clk,
   input  logic rst_n,
   input  logic wr,
   input  logic pub,
   input  logic din,
   output logic dout_bit
);
   logic shadow;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow   <= 1'b0;
         dout_bit <= 1'b0;
      end else begin
         if (wr)  shadow   <= din;
         // The lane written on the publishing edge forwards din directly.
         if (pub) dout_bit <= wr ? din : shadow;
      end
   end
endmodule

module demux_1x16_seq #(
   parameter int N    = 16,
   parameter int SELW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            din,
   input  logic            din_valid,
   input  logic            sof,
   output logic [N-1:0]    dout,
   output logic            dout_valid,
   output logic [SELW-1:0] slot,
   output logic            busy,
   output logic            err
);
   typedef enum logic {IDLE, COLLECT} state_t;

   localparam logic [SELW-1:0] LAST = SELW'(N - 1);

   state_t          state, state_n;
   logic [SELW-1:0] slot_q, slot_n;
   logic [SELW-1:0] wr_idx;
   logic            wr_any, pub, err_n;
   logic [N-1:0]    lane_wr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         slot_q     <= '0;
         dout_valid <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= state_n;
         slot_q     <= slot_n;
         dout_valid <= pub;
         err        <= err_n;
      end
   end

   always_comb begin
      state_n = state;
      slot_n  = slot_q;
      wr_any  = 1'b0;
      wr_idx  = '0;
      pub     = 1'b0;
      err_n   = 1'b0;
      case (state)
         IDLE: begin
            if (din_valid && sof) begin
               wr_any  = 1'b1;
               slot_n  = SELW'(1);
               state_n = COLLECT;
            end
         end
         COLLECT: begin
            if (din_valid) begin
               wr_any = 1'b1;
               if (sof) begin
                  // Restart: the sof bit is slot 0 of a fresh frame.
                  err_n  = 1'b1;
                  slot_n = SELW'(1);
               end else begin
                  wr_idx = slot_q;
                  if (slot_q == LAST) begin
                     pub     = 1'b1;
                     slot_n  = '0;
                     state_n = IDLE;
                  end else begin
                     slot_n = slot_q + SELW'(1);
                  end
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   genvar k;
   generate
      for (k = 0; k < N; k++) begin : g_lane
         assign lane_wr[k] = wr_any && (wr_idx == SELW'(k));
         demux_1x16_lane u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr       (lane_wr[k]),
            .pub      (pub),
            .din      (din),
            .dout_bit (dout[k])
         );
      end
   endgenerate

   assign slot = slot_q;
   assign busy = (state == COLLECT);
endmodule

// File: tb/tb_demux_1x16_seq.sv
// Scoreboard bench for demux_1x16_seq: expected frames are queued at stimulus time
// and a negedge monitor checks every dout_valid pulse against the queue.

module tb_demux_1x16_seq;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        din = 1'b0;
   logic        din_valid = 1'b0;
   logic        sof = 1'b0;
   logic [15:0] dout;
   logic        dout_valid;
   logic [3:0]  slot;
   logic        busy;
   logic        err;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          pulses = 0;
   int          err_seen = 0;
   int          exp_err = 0;
   logic [15:0] exp_q[$];
   int          vld_cyc[$];

   demux_1x16_seq dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din),
      .din_valid  (din_valid),
      .sof        (sof),
      .dout       (dout),
      .dout_valid (dout_valid),
      .slot       (slot),
      .busy       (busy),
      .err        (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops one expected word per dout_valid pulse.
   always @(negedge clk) begin
      if (rst_n) begin
         if (dout_valid && err) begin
            checks++;
            errors++;
            $display("FAIL valid_err_overlap: dout_valid=1 err=1 expected not both (cycle %0d)", cyc);
         end
         if (dout_valid) begin
            pulses++;
            vld_cyc.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_pulse: dout=%0h with no frame expected", dout);
            end else begin
               logic [15:0] e;
               e = exp_q.pop_front();
               if (dout !== e) begin
                  errors++;
                  $display("FAIL dout: got %0h expected %0h (cycle %0d)", dout, e, cyc);
               end
            end
         end
         if (err) err_seen++;
      end
   end

   task automatic send_bit(input logic d, input logic s);
      din = d; din_valid = 1'b1; sof = s;
      @(posedge clk); #1;
      din_valid = 1'b0; sof = 1'b0;
   endtask

   task automatic idle_cycle();
      din_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic send_frame(input logic [15:0] w, input bit gap, output int sof_cyc);
      sof_cyc = 0;
      for (int i = 0; i < 16; i++) begin
         if (i == 15) exp_q.push_back(w);
         send_bit(w[i], i == 0);
         if (i == 0) sof_cyc = cyc;
         if (i < 15) begin
            chk("busy_mid", busy, 1);
            chk("slot_mid", slot, i + 1);
            if (gap) begin
               idle_cycle();
               chk("slot_gap", slot, i + 1);
            end
         end else begin
            chk("busy_done", busy, 0);
            chk("slot_done", slot, 0);
         end
      end
   endtask

   task automatic wait_pulse(input int target);
      int k = 0;
      while (pulses < target && k < 8) begin
         @(posedge clk);
         k++;
      end
      #1;
      chk("pulse_count", pulses, target);
   endtask

   initial begin
      int s0, s1;
      int p;
      #2;
      chk("rst_dout", dout, 0);
      chk("rst_slot", slot, 0);
      chk("rst_busy", busy, 0);
      chk("rst_valid", dout_valid, 0);
      chk("rst_err", err, 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Contiguous frame.
      send_frame(16'hA5C3, 1'b0, s0);
      wait_pulse(1);
      chk("dout_hold_a5c3", dout, 16'hA5C3);

      // Abort at slot 7; the sof bit opens the all-ones frame.
      for (int i = 0; i < 7; i++) send_bit(1'b1, i == 0);
      chk("slot_before_abort", slot, 7);
      exp_err++;
      send_bit(1'b1, 1'b1);
      chk("err_pulse", err, 1);
      chk("slot_after_abort", slot, 1);
      chk("busy_after_abort", busy, 1);
      chk("dout_after_abort", dout, 16'hA5C3);
      for (int i = 1; i < 16; i++) begin
         if (i == 15) exp_q.push_back(16'hFFFF);
         send_bit(1'b1, 1'b0);
         if (i == 1) chk("err_one_cycle", err, 0);
      end
      wait_pulse(2);
      chk("dout_ffff", dout, 16'hFFFF);

      // Idle bits without sof are dropped.
      p = pulses;
      for (int i = 0; i < 5; i++) begin
         send_bit(1'b0, 1'b0);
         chk("idle_busy", busy, 0);
         chk("idle_slot", slot, 0);
         chk("idle_dout", dout, 16'hFFFF);
         chk("idle_valid", dout_valid, 0);
      end
      chk("idle_no_pulse", pulses, p);

      // Every-other-cycle frame: last bit lands 30 edges after sof.
      send_frame(16'h0001, 1'b1, s0);
      wait_pulse(3);
      chk("gap_latency", vld_cyc[vld_cyc.size()-1] - s0, 30);
      chk("dout_0001", dout, 16'h0001);

      // Back-to-back frames.
      send_frame(16'h1234, 1'b0, s0);
      send_frame(16'h5678, 1'b0, s1);
      wait_pulse(5);
      chk("b2b_spacing", vld_cyc[4] - vld_cyc[3], 16);
      chk("b2b_sof_spacing", s1 - s0, 16);

      // Asynchronous reset mid-frame at slot 9.
      for (int i = 0; i < 9; i++) send_bit(i[0] ? 1'b1 : 1'b0, i == 0);
      chk("slot_before_rst", slot, 9);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_dout", dout, 0);
      chk("arst_slot", slot, 0);
      chk("arst_busy", busy, 0);
      chk("arst_valid", dout_valid, 0);
      chk("arst_err", err, 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_slot", slot, 0);
      send_frame(16'hBEEF, 1'b0, s0);
      wait_pulse(6);
      chk("dout_beef", dout, 16'hBEEF);

      repeat (2) @(posedge clk);
      #1;
      chk("err_total", err_seen, exp_err);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
